// File: rtl/spi_register_bridge.sv
// SPI word to register-bus bridge: decodes frames, runs req/ack, builds MISO reply.
// Optional ack timeout enabled by defining SPI_REG_BRIDGE_TIMEOUT_EN.
module spi_register_bridge #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 24,
  parameter int WIDTH   = 1 + ADDR_W + DATA_W,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              system_clk,
  input  logic              system_rst,
  input  logic [WIDTH-1:0]  value_mosi,
  input  logic              value_valid,
  input  logic              cs_start,
  input  logic              cs_stop,
  output logic [WIDTH-1:0]  value_miso,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  overrun_count,
  output logic [CNT_W-1:0]  frame_error_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp_ok;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_pend;
  logic [WIDTH-1:0]  r_miso;
  logic [CNT_W-1:0]  r_ovr;
  logic [CNT_W-1:0]  r_ferr;
  logic [WIDTH-1:0]  w_rsp;

`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] r_tmo;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  assign w_rsp = {r_rsp_ok, r_addr, r_rsp_data};

  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_ok   <= 1'b0;
      r_rsp_data <= '0;
      r_pend     <= 1'b0;
      r_miso     <= '0;
`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
      r_tmo      <= '0;
`endif
    end else begin
      // Deferred reply: slave loaded MISO in the DONE cycle
      if (r_pend) begin
        r_miso <= w_rsp;
        r_pend <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (value_valid) begin
            r_we    <= value_mosi[WIDTH-1];
            r_addr  <= value_mosi[DATA_W +: ADDR_W];
            r_wdata <= value_mosi[DATA_W-1:0];
            r_req   <= 1'b1;
            r_state <= S_REQ;
`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
            r_tmo   <= '0;
`endif
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            r_req      <= 1'b0;
            r_rsp_ok   <= 1'b1;
            r_rsp_data <= r_we ? r_wdata : bus_rdata;
            r_state    <= S_DONE;
          end
`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
          else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            r_req      <= 1'b0;
            r_rsp_ok   <= 1'b0;
            r_rsp_data <= '0;
            r_state    <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (cs_start) r_pend <= 1'b1;
          else          r_miso <= w_rsp;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      r_ovr  <= '0;
      r_ferr <= '0;
    end else begin
      if (value_valid && (r_state != S_IDLE) && (r_ovr != '1))
        r_ovr <= r_ovr + 1'b1;
      if (cs_stop && !value_valid && (r_ferr != '1))
        r_ferr <= r_ferr + 1'b1;
    end
  end

  assign value_miso        = r_miso;
  assign bus_req           = r_req;
  assign bus_we            = r_we;
  assign bus_addr          = r_addr;
  assign bus_wdata         = r_wdata;
  assign busy              = (r_state != S_IDLE);
  assign overrun_count     = r_ovr;
  assign frame_error_count = r_ferr;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Directed self-checking bench for spi_register_bridge.
// Timeout steps run only when SPI_REG_BRIDGE_TIMEOUT_EN is defined.
module tb_spi_register_bridge;

`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
  localparam int TB_TMO = 10;
`else
  localparam int TB_TMO = 255;
`endif

  logic        system_clk = 1'b0;
  logic        system_rst = 1'b1;
  logic [31:0] value_mosi = '0;
  logic        value_valid = 1'b0;
  logic        cs_start = 1'b0;
  logic        cs_stop = 1'b0;
  logic [31:0] value_miso;
  logic        bus_req;
  logic        bus_we;
  logic [6:0]  bus_addr;
  logic [23:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [23:0] bus_rdata = '0;
  logic        busy;
  logic [7:0]  overrun_count;
  logic [7:0]  frame_error_count;

  int n_chk = 0;
  int n_err = 0;

  spi_register_bridge #(.TIMEOUT(TB_TMO)) dut (
    .system_clk       (system_clk),
    .system_rst       (system_rst),
    .value_mosi       (value_mosi),
    .value_valid      (value_valid),
    .cs_start         (cs_start),
    .cs_stop          (cs_stop),
    .value_miso       (value_miso),
    .bus_req          (bus_req),
    .bus_we           (bus_we),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_ack          (bus_ack),
    .bus_rdata        (bus_rdata),
    .busy             (busy),
    .overrun_count    (overrun_count),
    .frame_error_count(frame_error_count)
  );

  always #5 system_clk = ~system_clk;

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    step();
    chk("rst_miso", value_miso, 32'h0);
    chk("rst_req", {31'b0, bus_req}, 32'h0);
    chk("rst_we", {31'b0, bus_we}, 32'h0);
    chk("rst_addr", {25'b0, bus_addr}, 32'h0);
    chk("rst_wdata", {8'b0, bus_wdata}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ovr", {24'b0, overrun_count}, 32'h0);
    chk("rst_ferr", {24'b0, frame_error_count}, 32'h0);
    system_rst = 1'b0;
    step();

    // 1: write, ack after 3 cycles; cs_stop with valid is not an error
    value_mosi  = {1'b1, 7'h05, 24'hABCDEF};
    value_valid = 1'b1;
    cs_stop     = 1'b1;
    step();
    value_valid = 1'b0;
    cs_stop     = 1'b0;
    chk("w_req", {31'b0, bus_req}, 32'h1);
    chk("w_we", {31'b0, bus_we}, 32'h1);
    chk("w_addr", {25'b0, bus_addr}, 32'h05);
    chk("w_wdata", {8'b0, bus_wdata}, 32'hABCDEF);
    chk("w_busy", {31'b0, busy}, 32'h1);
    chk("w_ferr", {24'b0, frame_error_count}, 32'h0);
    step();
    step();
    chk("w_req_hold", {31'b0, bus_req}, 32'h1);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    chk("w_req_drop", {31'b0, bus_req}, 32'h0);
    step();
    chk("w_miso", value_miso, 32'h85ABCDEF);
    chk("w_idle", {31'b0, busy}, 32'h0);

    // 2: read with 0-wait ack
    value_mosi  = {1'b0, 7'h12, 24'hFFFFFF};
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    chk("r_req", {31'b0, bus_req}, 32'h1);
    chk("r_we", {31'b0, bus_we}, 32'h0);
    bus_ack   = 1'b1;
    bus_rdata = 24'h123456;
    step();
    bus_ack   = 1'b0;
    bus_rdata = 24'h0;
    chk("r_req_1cyc", {31'b0, bus_req}, 32'h0);
    step();
    chk("r_miso", value_miso, 32'h92123456);

    // 3: overrun drops frame, then saturation
    value_mosi  = {1'b1, 7'h33, 24'h000111};
    value_valid = 1'b1;
    step();
    value_mosi = {1'b1, 7'h44, 24'h000044};
    step();
    value_valid = 1'b0;
    chk("ovr_one", {24'b0, overrun_count}, 32'h1);
    chk("ovr_addr", {25'b0, bus_addr}, 32'h33);
    bus_ack = 1'b1;
    step();
    bus_ack = 1'b0;
    step();
    chk("ovr_miso", value_miso, 32'hB3000111);
    for (int i = 0; i < 255; i++) begin
      if (i == 254)
        chk("ovr_255", {24'b0, overrun_count}, 32'hFF);
      value_mosi  = {1'b1, 7'h44, 24'h000044};
      value_valid = 1'b1;
      step();
      bus_ack = 1'b1;
      step();
      value_valid = 1'b0;
      bus_ack     = 1'b0;
      step();
    end
    chk("ovr_sat", {24'b0, overrun_count}, 32'hFF);
    chk("loop_miso", value_miso, 32'hC4000044);

    // 4: cs_stop without value_valid
    cs_stop = 1'b1;
    step();
    cs_stop = 1'b0;
    chk("ferr_one", {24'b0, frame_error_count}, 32'h1);
    chk("ferr_noreq", {31'b0, bus_req}, 32'h0);
    chk("ferr_idle", {31'b0, busy}, 32'h0);

    // 5: DONE coincident with cs_start defers update
    value_mosi  = {1'b1, 7'h55, 24'hCAFE00};
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    bus_ack     = 1'b1;
    step();
    bus_ack  = 1'b0;
    cs_start = 1'b1;
    step();
    cs_start = 1'b0;
    chk("defer_old", value_miso, 32'hC4000044);
    step();
    chk("defer_new", value_miso, 32'hD5CAFE00);

    // 5b: reset in REQ
    value_mosi  = {1'b1, 7'h7F, 24'h0F0F0F};
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    chk("mid_req", {31'b0, bus_req}, 32'h1);
    system_rst = 1'b1;
    step();
    system_rst = 1'b0;
    chk("mid_rst_req", {31'b0, bus_req}, 32'h0);
    chk("mid_rst_miso", value_miso, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_addr", {25'b0, bus_addr}, 32'h0);
    chk("mid_rst_wdata", {8'b0, bus_wdata}, 32'h0);
    chk("mid_rst_ovr", {24'b0, overrun_count}, 32'h0);
    chk("mid_rst_ferr", {24'b0, frame_error_count}, 32'h0);
    step();
    chk("mid_rst_norsp", value_miso, 32'h0);

`ifdef SPI_REG_BRIDGE_TIMEOUT_EN
    // 6: no ack -> req drops after 10 cycles, ok=0 reply
    value_mosi  = {1'b1, 7'h0A, 24'h111111};
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    chk("tmo_req0", {31'b0, bus_req}, 32'h1);
    repeat (9) step();
    chk("tmo_req9", {31'b0, bus_req}, 32'h1);
    step();
    chk("tmo_drop", {31'b0, bus_req}, 32'h0);
    step();
    chk("tmo_miso", value_miso, 32'h0A000000);
    bus_ack   = 1'b1;
    bus_rdata = 24'hDEAD00;
    step();
    bus_ack = 1'b0;
    chk("tmo_late_miso", value_miso, 32'h0A000000);
    chk("tmo_late_busy", {31'b0, busy}, 32'h0);
    chk("tmo_late_req", {31'b0, bus_req}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
